// File: rtl/detection_tracker.sv
`default_nettype none
// ============================================================================
// Module   : detection_tracker
// Purpose  : Per-frame face-detection tracker with lock-in, drop hysteresis and
//            a short detection hold for the overlay stage.
// Revision : 1.0 - initial release
// ============================================================================
module detection_tracker #(
  parameter int CONT_FRAMES = 8,
  parameter int DROP_FRAMES = 3,
  parameter int HOLD_FRAMES = 2
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       detect_strobe,
  input  logic       enable,
  output logic       detected_flag,
  output logic       continuous,
  output logic [7:0] streak_out
);

  localparam logic [7:0] c_cont_frames = CONT_FRAMES[7:0];
  localparam logic [7:0] c_drop_frames = DROP_FRAMES[7:0];
  localparam logic [7:0] c_hold_frames = HOLD_FRAMES[7:0];
  localparam logic [7:0] c_sat_max     = 8'hFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACKING = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_vsync_d;
  logic       r_armed;
  logic       r_hit, w_hit_nxt;
  logic [7:0] r_streak, w_streak_nxt;
  logic [7:0] r_miss, w_miss_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic       w_boundary;

  // r_armed blocks a boundary until vsync has been seen low after reset.
  assign w_boundary = vsync_in & ~r_vsync_d & r_armed;

  always_comb begin
    w_state_nxt  = r_state;
    w_hit_nxt    = r_hit | detect_strobe;
    w_streak_nxt = r_streak;
    w_miss_nxt   = r_miss;
    w_hold_nxt   = r_hold;

    if (w_boundary) begin
      w_hit_nxt = detect_strobe;
      if (r_hit) begin
        w_streak_nxt = (r_streak == c_sat_max) ? c_sat_max : r_streak + 8'd1;
        w_miss_nxt   = 8'd0;
        w_hold_nxt   = c_hold_frames;
      end else begin
        w_streak_nxt = 8'd0;
        w_miss_nxt   = (r_miss == c_sat_max) ? c_sat_max : r_miss + 8'd1;
        w_hold_nxt   = (r_hold == 8'd0) ? 8'd0 : r_hold - 8'd1;
      end

      case (r_state)
        IDLE: begin
          if (r_hit) begin
            w_state_nxt = (w_streak_nxt >= c_cont_frames) ? LOCKED : TRACKING;
          end
        end
        TRACKING: begin
          if (!r_hit) begin
            w_state_nxt = IDLE;
          end else if (w_streak_nxt >= c_cont_frames) begin
            w_state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (!r_hit && (w_miss_nxt >= c_drop_frames)) begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end

    if (!enable) begin
      w_state_nxt  = IDLE;
      w_hit_nxt    = 1'b0;
      w_streak_nxt = 8'd0;
      w_miss_nxt   = 8'd0;
      w_hold_nxt   = 8'd0;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_vsync_d     <= 1'b0;
      r_armed       <= ~vsync_in;
      r_hit         <= 1'b0;
      r_streak      <= 8'd0;
      r_miss        <= 8'd0;
      r_hold        <= 8'd0;
      detected_flag <= 1'b0;
      continuous    <= 1'b0;
      streak_out    <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_vsync_d     <= vsync_in;
      r_armed       <= r_armed | ~vsync_in;
      r_hit         <= w_hit_nxt;
      r_streak      <= w_streak_nxt;
      r_miss        <= w_miss_nxt;
      r_hold        <= w_hold_nxt;
      // Outputs load from the same next values so they land with the counters.
      detected_flag <= (w_hold_nxt != 8'd0);
      continuous    <= (w_state_nxt == LOCKED);
      streak_out    <= w_streak_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_detection_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_detection_tracker
// Purpose  : Directed, table-driven self-checking bench for detection_tracker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_detection_tracker;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic       detect_strobe;
  logic       enable;
  logic       detected_flag;
  logic       continuous;
  logic [7:0] streak_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         n;
    logic       f;
    logic       c;
    logic [7:0] s;
  } vec_t;

  vec_t tbl [17];

  detection_tracker #(
    .CONT_FRAMES(8),
    .DROP_FRAMES(3),
    .HOLD_FRAMES(2)
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .vsync_in     (vsync_in),
    .detect_strobe(detect_strobe),
    .enable       (enable),
    .detected_flag(detected_flag),
    .continuous   (continuous),
    .streak_out   (streak_out)
  );

  always #5 pclk = ~pclk;

  task automatic cyc(input logic v, input logic s, input logic e);
    vsync_in      = v;
    detect_strobe = s;
    enable        = e;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic f, input logic c, input logic [7:0] s);
    chk({name, ".detected_flag"}, {31'd0, detected_flag}, {31'd0, f});
    chk({name, ".continuous"}, {31'd0, continuous}, {31'd0, c});
    chk({name, ".streak_out"}, {24'd0, streak_out}, {24'd0, s});
  endtask

  // Remainder of a frame after its boundary: two more high cycles, then six
  // low cycles carrying n strobes.
  task automatic body(input int n);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, (i < n), 1'b1);
    end
  endtask

  task automatic boundary(input logic s);
    cyc(1'b1, s, 1'b1);
  endtask

  initial begin
    tbl[0]  = '{0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1, 1'b1, 1'b0, 8'd1};
    tbl[2]  = '{0, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{0, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{0, 1'b0, 1'b0, 8'd0};
    tbl[5]  = '{5, 1'b1, 1'b0, 8'd1};
    tbl[6]  = '{1, 1'b1, 1'b0, 8'd2};
    tbl[7]  = '{1, 1'b1, 1'b0, 8'd3};
    tbl[8]  = '{1, 1'b1, 1'b0, 8'd4};
    tbl[9]  = '{1, 1'b1, 1'b0, 8'd5};
    tbl[10] = '{1, 1'b1, 1'b0, 8'd6};
    tbl[11] = '{1, 1'b1, 1'b0, 8'd7};
    tbl[12] = '{1, 1'b1, 1'b1, 8'd8};
    tbl[13] = '{0, 1'b1, 1'b1, 8'd0};
    tbl[14] = '{0, 1'b0, 1'b1, 8'd0};
    tbl[15] = '{0, 1'b0, 1'b0, 8'd0};
    tbl[16] = '{1, 1'b1, 1'b0, 8'd1};

    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    chk_out("reset", 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    boundary(1'b0);
    chk_out("first_boundary", 1'b0, 1'b0, 8'd0);

    for (int k = 0; k < 17; k++) begin
      body(tbl[k].n);
      boundary(1'b0);
      chk_out($sformatf("vec%0d", k), tbl[k].f, tbl[k].c, tbl[k].s);
    end

    // Strobe on the boundary cycle belongs to the frame that is starting.
    body(0);
    boundary(1'b1);
    chk_out("coincident_now", 1'b1, 1'b0, 8'd0);
    body(0);
    chk_out("coincident_midframe", 1'b1, 1'b0, 8'd0);
    boundary(1'b0);
    chk_out("coincident_next", 1'b1, 1'b0, 8'd1);

    for (int k = 0; k < 300; k++) begin
      body(1);
      boundary(1'b0);
    end
    chk_out("saturate", 1'b1, 1'b1, 8'd255);

    // Reset mid-frame while LOCKED with a hit already latched.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    chk_out("rst_locked", 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    boundary(1'b0);
    chk_out("rst_discard_hit", 1'b0, 1'b0, 8'd0);

    for (int k = 0; k < 8; k++) begin
      body(1);
      boundary(1'b0);
    end
    chk_out("relock", 1'b1, 1'b1, 8'd8);

    // Disable while LOCKED; strobes and a vsync edge during disable are ignored.
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk_out("disable_locked", 1'b0, 1'b0, 8'd0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk_out("disabled_hold", 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 1'b1);
    body(1);
    boundary(1'b0);
    chk_out("reenable", 1'b1, 1'b0, 8'd1);

    // vsync already high as reset releases: no boundary until low then high.
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    chk_out("vsync_high_at_reset", 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 1'b0, 1'b1);
    boundary(1'b0);
    chk_out("first_real_boundary", 1'b1, 1'b0, 8'd1);
    body(0);
    boundary(1'b0);
    chk_out("after_real_boundary", 1'b1, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
